// File: rtl/fp32_pkg.sv
// rtl/fp32_pkg.sv - shared IEEE-754 single-precision constants, FSM states and field helpers
package fp32_pkg;

  localparam int EXP_BIAS = 127;
  localparam int EXP_W    = 8;
  localparam int MANT_W   = 23;

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF = 32'h7F80_0000;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_UNPACK = 3'd1,
    ST_MUL    = 3'd2,
    ST_ROUND  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  function automatic logic fp_sign(input logic [31:0] x);
    return x[31];
  endfunction

  function automatic logic [EXP_W-1:0] fp_exp(input logic [31:0] x);
    return x[30:23];
  endfunction

  function automatic logic [MANT_W-1:0] fp_mant(input logic [31:0] x);
    return x[22:0];
  endfunction

  function automatic logic fp_is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != '0);
  endfunction

  function automatic logic fp_is_inf(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] == '0);
  endfunction

  // Denormals are flushed, so a zero exponent field means zero.
  function automatic logic fp_is_zero(input logic [31:0] x);
    return x[30:23] == 8'h00;
  endfunction

endpackage

// File: rtl/fp_normalize_round.sv
// rtl/fp_normalize_round.sv - normalise a 48-bit significand product, round to nearest-even, pack
//
// Purpose: combinational back end shared by the multiplier and divider.
// Ports:
//   sign_i      result sign
//   exp_i       biased exponent before normalisation, 10-bit two's complement
//   prod_i      48-bit significand product with the binary point after bit 46
//   result_o    packed IEEE-754 single result
//   overflow_o  result saturated to signed infinity
//   underflow_o result flushed to signed zero
module fp_normalize_round
  import fp32_pkg::*;
(
  input  logic               sign_i,
  input  logic signed [9:0]  exp_i,
  input  logic [47:0]        prod_i,
  output logic [31:0]        result_o,
  output logic               overflow_o,
  output logic               underflow_o
);

  logic [MANT_W-1:0] mant;
  logic              guard;
  logic              sticky;
  logic              inc;
  logic [MANT_W:0]   rounded;
  logic signed [9:0] exp_norm;
  logic signed [9:0] exp_final;

  always_comb begin
    mant        = '0;
    guard       = 1'b0;
    sticky      = 1'b0;
    exp_norm    = exp_i;
    inc         = 1'b0;
    rounded     = '0;
    exp_final   = exp_i;
    result_o    = '0;
    overflow_o  = 1'b0;
    underflow_o = 1'b0;

    // Product of two 1.x significands lies in [1,4); bit 47 set means >= 2.
    if (prod_i[47]) begin
      mant     = prod_i[46:24];
      guard    = prod_i[23];
      sticky   = |prod_i[22:0];
      exp_norm = exp_i + 10'sd1;
    end else begin
      mant     = prod_i[45:23];
      guard    = prod_i[22];
      sticky   = |prod_i[21:0];
      exp_norm = exp_i;
    end

    inc     = guard & (sticky | mant[0]);
    rounded = {1'b0, mant} + {{MANT_W{1'b0}}, inc};

    // A carry out leaves the stored mantissa at zero, i.e. exactly 1.0 at the next exponent.
    exp_final = rounded[MANT_W] ? exp_norm + 10'sd1 : exp_norm;

    if (exp_final >= 10'sd255) begin
      result_o   = POS_INF | {sign_i, 31'b0};
      overflow_o = 1'b1;
    end else if (exp_final <= 10'sd0) begin
      result_o    = {sign_i, 31'b0};
      underflow_o = 1'b1;
    end else begin
      result_o = {sign_i, exp_final[EXP_W-1:0], rounded[MANT_W-1:0]};
    end
  end

endmodule

// File: rtl/fp_multiplier.sv
// rtl/fp_multiplier.sv - sequential IEEE-754 single-precision multiplier with start/done handshake
//
// Purpose: radix-2^BITS_PER_CYCLE shift-add significand multiply, then normalise/round/pack.
// Ports:
//   control    clock, rising edge
//   reset      asynchronous active-low reset
//   start      request a multiply (sampled in IDLE only)
//   A, B       IEEE-754 single operands
//   busy       operation in progress (UNPACK, MUL, ROUND)
//   done       one-cycle pulse; out and flags valid from this cycle
//   out        product, held until the next done
//   exception  NaN/infinity operand, invalid operation, or overflow
//   underflow  result flushed to signed zero
module fp_multiplier
  import fp32_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 1
)
(
  input  logic        control,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        done,
  output logic [31:0] out,
  output logic        exception,
  output logic        underflow
);

  localparam int         MUL_CYCLES = 24 / BITS_PER_CYCLE;
  localparam logic [4:0] CNT_LOAD   = 5'(MUL_CYCLES - 1);

  state_t      state_q, state_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic        sign_q, sign_d;
  logic [9:0]  exp_q, exp_d;
  logic [47:0] acc_q, acc_d;
  logic [47:0] mc_q, mc_d;     // multiplicand, shifted left as multiplier bits retire
  logic [23:0] mq_q, mq_d;     // multiplier, shifted right as bits retire
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] out_q, out_d;
  logic        exc_q, exc_d;
  logic        unf_q, unf_d;

  logic [47:0] step_sum;
  logic [31:0] nr_result;
  logic        nr_ovf;
  logic        nr_unf;
  logic        sign_ab;
  logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

  fp_normalize_round u_norm (
    .sign_i      (sign_q),
    .exp_i       (exp_q),
    .prod_i      (acc_q),
    .result_o    (nr_result),
    .overflow_o  (nr_ovf),
    .underflow_o (nr_unf)
  );

  always_ff @(posedge control or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sign_q  <= 1'b0;
      exp_q   <= '0;
      acc_q   <= '0;
      mc_q    <= '0;
      mq_q    <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      exc_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sign_q  <= sign_d;
      exp_q   <= exp_d;
      acc_q   <= acc_d;
      mc_q    <= mc_d;
      mq_q    <= mq_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      exc_q   <= exc_d;
      unf_q   <= unf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sign_d  = sign_q;
    exp_d   = exp_q;
    acc_d   = acc_q;
    mc_d    = mc_q;
    mq_d    = mq_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    exc_d   = exc_q;
    unf_d   = unf_q;

    sign_ab = fp_sign(a_q) ^ fp_sign(b_q);
    a_nan   = fp_is_nan(a_q);
    b_nan   = fp_is_nan(b_q);
    a_inf   = fp_is_inf(a_q);
    b_inf   = fp_is_inf(b_q);
    a_zero  = fp_is_zero(a_q);
    b_zero  = fp_is_zero(b_q);

    step_sum = acc_q;
    for (int k = 0; k < BITS_PER_CYCLE; k++) begin
      if (mq_q[k]) step_sum = step_sum + (mc_q << k);
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          state_d = ST_UNPACK;
        end
      end

      ST_UNPACK: begin
        sign_d  = sign_ab;
        exp_d   = {2'b00, fp_exp(a_q)} + {2'b00, fp_exp(b_q)} - 10'(EXP_BIAS);
        acc_d   = '0;
        mc_d    = {24'b0, 1'b1, fp_mant(a_q)};
        mq_d    = {1'b1, fp_mant(b_q)};
        cnt_d   = CNT_LOAD;
        state_d = ST_MUL;
        if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) begin
          out_d   = QNAN;
          exc_d   = 1'b1;
          unf_d   = 1'b0;
          state_d = ST_DONE;
        end else if (a_inf || b_inf) begin
          out_d   = POS_INF | {sign_ab, 31'b0};
          exc_d   = 1'b1;
          unf_d   = 1'b0;
          state_d = ST_DONE;
        end else if (a_zero || b_zero) begin
          out_d   = {sign_ab, 31'b0};
          exc_d   = 1'b0;
          unf_d   = 1'b0;
          state_d = ST_DONE;
        end
      end

      ST_MUL: begin
        acc_d = step_sum;
        mc_d  = mc_q << BITS_PER_CYCLE;
        mq_d  = mq_q >> BITS_PER_CYCLE;
        if (cnt_q == 5'd0) begin
          state_d = ST_ROUND;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end

      ST_ROUND: begin
        out_d   = nr_result;
        exc_d   = nr_ovf;
        unf_d   = nr_unf;
        state_d = ST_DONE;
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy      = (state_q == ST_UNPACK) || (state_q == ST_MUL) || (state_q == ST_ROUND);
  assign done      = (state_q == ST_DONE);
  assign out       = out_q;
  assign exception = exc_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_fp_multiplier.sv
// tb/tb_fp_multiplier.sv - scoreboard bench for fp_multiplier at BITS_PER_CYCLE 1 and 4
module tb_fp_multiplier;

  typedef struct {
    logic [31:0] out;
    logic        exc;
    logic        unf;
    int          cyc;
    string       name;
  } exp_t;

  logic        control = 1'b0;
  logic        rst_n   = 1'b0;
  logic        start   = 1'b0;
  logic [31:0] A       = '0;
  logic [31:0] B       = '0;

  logic        busy1, done1, exc1, unf1;
  logic [31:0] out1;
  logic        busy4, done4, exc4, unf4;
  logic [31:0] out4;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  exp_t q1[$];
  exp_t q4[$];

  fp_multiplier #(.BITS_PER_CYCLE(1)) dut1 (
    .control(control), .reset(rst_n), .start(start), .A(A), .B(B),
    .busy(busy1), .done(done1), .out(out1), .exception(exc1), .underflow(unf1)
  );

  fp_multiplier #(.BITS_PER_CYCLE(4)) dut4 (
    .control(control), .reset(rst_n), .start(start), .A(A), .B(B),
    .busy(busy4), .done(done4), .out(out4), .exception(exc4), .underflow(unf4)
  );

  always #5 control = ~control;
  always @(posedge control) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask

  task automatic compare(input string who, input exp_t e, input logic [31:0] o,
                         input logic x, input logic u);
    chk({who, "_", e.name, "_out"}, o, e.out);
    chk({who, "_", e.name, "_exc"}, {31'b0, x}, {31'b0, e.exc});
    chk({who, "_", e.name, "_unf"}, {31'b0, u}, {31'b0, e.unf});
    chk({who, "_", e.name, "_done_cycle"}, 32'(cyc), 32'(e.cyc));
  endtask

  // Monitors: every done pulse must match the oldest outstanding expectation.
  always @(negedge control) begin
    if (rst_n && done1) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut1_unexpected_done: got done at cycle %0d, expected none", cyc);
      end else begin
        compare("dut1", q1.pop_front(), out1, exc1, unf1);
      end
    end
  end

  always @(negedge control) begin
    if (rst_n && done4) begin
      if (q4.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut4_unexpected_done: got done at cycle %0d, expected none", cyc);
      end else begin
        compare("dut4", q4.pop_front(), out4, exc4, unf4);
      end
    end
  end

  // Drives one start pulse; start is sampled at edge s. Done is visible after edge s+lat-1.
  task automatic issue(input string name, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eo, input logic ex, input logic un, input bit fast,
                       output int s);
    exp_t e;
    @(negedge control);
    A = a; B = b; start = 1'b1;
    s = cyc + 1;
    e.out = eo; e.exc = ex; e.unf = un; e.name = name;
    e.cyc = s + (fast ? 1 : 26);
    q1.push_back(e);
    e.cyc = s + (fast ? 1 : 8);
    q4.push_back(e);
    @(negedge control);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 100 && (q1.size() != 0 || q4.size() != 0); i++) @(negedge control);
    checks++;
    if (q1.size() != 0 || q4.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: got %0d/%0d pending results, expected 0", name, q1.size(), q4.size());
      q1.delete();
      q4.delete();
    end
    @(negedge control);
  endtask

  initial begin
    int s;
    int bad;

    repeat (3) @(negedge control);
    chk("reset_out", out1, 32'h0);
    chk("reset_busy", {31'b0, busy1}, 32'h0);
    chk("reset_done", {31'b0, done1}, 32'h0);
    chk("reset_exc", {31'b0, exc1}, 32'h0);
    chk("reset_unf", {31'b0, unf1}, 32'h0);
    rst_n = 1'b1;
    @(negedge control);

    // 2.0 * 3.0 with busy window check on the radix-2 instance.
    issue("2x3", 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 1'b0, 1'b0, 1'b0, s);
    bad = 0;
    for (int i = 0; i < 26; i++) begin
      if (!busy1) bad++;
      @(negedge control);
    end
    chk("busy_window_low_count", 32'(bad), 32'h0);
    chk("busy_in_done_cycle", {31'b0, busy1}, 32'h0);
    wait_idle("2x3");

    issue("1p5xm2p5", 32'h3FC0_0000, 32'hC020_0000, 32'hC070_0000, 1'b0, 1'b0, 1'b0, s);
    wait_idle("1p5xm2p5");
    issue("infx0", 32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, 1'b1, 1'b0, 1'b1, s);
    wait_idle("infx0");
    issue("ovf", 32'h7F00_0000, 32'h4000_0000, 32'h7F80_0000, 1'b1, 1'b0, 1'b0, s);
    wait_idle("ovf");
    issue("unf", 32'h0080_0000, 32'h0080_0000, 32'h0000_0000, 1'b0, 1'b1, 1'b0, s);
    wait_idle("unf");
    issue("rne", 32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0002, 1'b0, 1'b0, 1'b0, s);
    wait_idle("rne");
    issue("nan", 32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, 1'b1, 1'b0, 1'b1, s);
    wait_idle("nan");
    issue("neginfx2", 32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, 1'b1, 1'b0, 1'b1, s);
    wait_idle("neginfx2");
    issue("negzero", 32'h8000_0000, 32'h3F80_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b1, s);
    wait_idle("negzero");
    issue("maxmant", 32'h3FFF_FFFF, 32'h3FFF_FFFF, 32'h407F_FFFE, 1'b0, 1'b0, 1'b0, s);
    wait_idle("maxmant");

    // Abort: reset asserted just after edge s+10 for one cycle; no done for that op.
    issue("aborted", 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 1'b0, 1'b0, 1'b0, s);
    repeat (9) @(negedge control);
    @(posedge control);
    #1;
    rst_n = 1'b0;
    q1.delete();
    #1;
    chk("abort_out_cleared", out1, 32'h0);
    chk("abort_busy_cleared", {31'b0, busy1}, 32'h0);
    @(posedge control);
    #1;
    rst_n = 1'b1;
    issue("after_abort", 32'h4000_0000, 32'h4000_0000, 32'h4080_0000, 1'b0, 1'b0, 1'b0, s);
    wait_idle("after_abort");

    // Extra start pulses at s+5 and s+15: dut1 is busy for both, dut4 is idle again by s+15.
    issue("ignore", 32'h3FC0_0000, 32'hC020_0000, 32'hC070_0000, 1'b0, 1'b0, 1'b0, s);
    repeat (4) @(negedge control);
    A = 32'h4000_0000; B = 32'h4040_0000; start = 1'b1;
    @(negedge control);
    start = 1'b0;
    repeat (9) @(negedge control);
    start = 1'b1;
    begin
      exp_t e;
      e.out = 32'h40C0_0000; e.exc = 1'b0; e.unf = 1'b0; e.name = "late_start";
      e.cyc = s + 15 + 8;
      q4.push_back(e);
    end
    @(negedge control);
    start = 1'b0;
    wait_idle("ignore");
    repeat (5) @(negedge control);
    chk("ignore_result_held", out1, 32'hC070_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
